line_mem_responder: RTL and testbench
=====================================

// Module: line_mem_responder
// PURPOSE
//   Memory-side responder for the cache's 128-bit line interface: services line reads (fills) and
//   line writes (dirty write-backs) issued by the cache datapath/control, after a programmable latency.
//   Sits below the cache as physical memory (sim and FPGA BRAM target); one request in flight at a time.
// PARAMETERS
//   LATENCY   4   cycles from request acceptance to mem_resp pulse (legal range 1..255)
//   IDX_BITS  12  line-index width; depth = 2**IDX_BITS lines of 128 bits (12 -> full 64 KB space)
// PORTS
//   clk        in   1    clock, rising edge
//   rst_n      in   1    asynchronous, active-low reset
//   mem_read   in   1    line read request; held by cache until mem_resp
//   mem_write  in   1    line write request; held by cache until mem_resp
//   mem_addr   in   16   byte address (lc3b_word); line index = mem_addr[4+IDX_BITS-1:4]
//   mem_wdata  in   128  write line (lc3b_8words)
//   mem_rdata  out  128  read line (lc3b_8words); valid only while mem_resp=1
//   mem_resp   out  1    one-cycle completion pulse for the accepted request
//   mem_err    out  1    alignment error flag (only with LINE_MEM_ALIGN_CHECK_EN; else tied 0)
// BEHAVIOUR
//   - Reset (async assert, sync deassert by flops): state=IDLE, counter=0, mem_resp=0, mem_rdata=0,
//     mem_err=0. Storage array is NOT reset; contents survive reset.
//   - FSM: IDLE -> BUSY when (mem_read|mem_write); latches op, line index, wdata at that edge.
//     BUSY: counter counts 1..LATENCY-1; when counter==LATENCY-1 -> RESP (LATENCY=1: IDLE->RESP directly).
//     RESP: mem_resp=1 for exactly one cycle; read: mem_rdata = stored line at latched index;
//     write: latched wdata committed to array at the RESP->IDLE edge. RESP -> IDLE unconditionally.
//   - Latency: request seen at edge N -> mem_resp high in cycle N+LATENCY.
//   - IDLE always spends >=1 cycle after RESP; cache drops request on the resp edge, so no re-trigger.
//   - Request deasserted during BUSY: latched op still completes and mem_resp still pulses.
//   - Address/wdata changes during BUSY: ignored (latched copy used).
//   - mem_read & mem_write together: write takes priority; read is dropped.
//   - mem_addr[3:0] and bits above 4+IDX_BITS-1 ignored (upper bits alias).
//   - Read-after-write same line: next read returns the written data (commit precedes next accept).
//   - Reset mid-BUSY/RESP: operation aborted, no array write, mem_resp stays 0.
//   - mem_rdata holds 0 outside RESP (no stale data on the bus).
// CONFIGURATION
//   LINE_MEM_ALIGN_CHECK_EN defined: on accept, mem_addr[3:0]!=0 latches err; in RESP mem_err=1
//     alongside mem_resp, read returns 128'h0, write is NOT committed.
//   Undefined: mem_err tied 0, low address bits silently ignored, access proceeds normally.
// STRUCTURE
//   lc3b_types: add lc3b_line_idx typedef (sized from shared IDX_BITS constant), LINE_MEM_LAT_DEF
//     constant, and enum lc3b_mem_state_t {MEM_IDLE, MEM_BUSY, MEM_RESP}.
//   Sub-module line_store: 2**IDX_BITS x 128 array, sync write, combinational read, no reset.
//   Top: FSM, latency counter, request latches, output gating.
// TESTING
//   Reset, then read line 0x0010 (addr 16'h0100) LATENCY=4 -> mem_resp in 4th cycle, mem_rdata=init.
//   Write 16'h0230 data 128'hDEAD..BEEF, then read 16'h0230 -> resp after 4 each, rdata=DEAD..BEEF.
//   read&write both high, addr 16'h0040 -> write committed, one resp; readback shows wdata.
//   Drop mem_read after 1 cycle in BUSY -> resp still pulses at cycle 4; FSM back to IDLE.
//   Assert rst_n=0 mid-BUSY of write to 16'h0500 -> no resp; readback returns old line.
//   ALIGN_CHECK_EN, write addr 16'h0502 -> mem_err=1 with mem_resp, line 0x050 unchanged.

Source files
------------

// File: rtl/lc3b_types.sv
// Shared LC-3b memory-side types: line/word typedefs, line-index width, default latency, responder states.
// The optional alignment check in line_mem_responder is enabled with LINE_MEM_ALIGN_CHECK_EN.
package lc3b_types;

    typedef logic [15:0]  lc3b_word;
    typedef logic [127:0] lc3b_8words;

    localparam int LINE_IDX_BITS    = 12;
    localparam int LINE_MEM_LAT_DEF = 4;

    typedef logic [LINE_IDX_BITS-1:0] lc3b_line_idx;

    typedef enum logic [1:0] {
        MEM_IDLE,
        MEM_BUSY,
        MEM_RESP
    } lc3b_mem_state_t;

    // A line access is aligned only when the byte offset within the 16-byte line is zero.
    function automatic logic addr_misaligned(input lc3b_word addr);
        return addr[3:0] != 4'h0;
    endfunction

endpackage

// File: rtl/line_store.sv
// Line storage for the memory responder: 2**IDX_BITS lines of 128 bits,
// synchronous write, combinational read, deliberately not reset so contents survive reset.
module line_store
    import lc3b_types::*;
#(
    parameter int IDX_BITS = LINE_IDX_BITS
) (
    input  logic                clk_i,
    input  logic                we_i,
    input  logic [IDX_BITS-1:0] waddr_i,
    input  lc3b_8words          wdata_i,
    input  logic [IDX_BITS-1:0] raddr_i,
    output lc3b_8words          rdata_o
);

    lc3b_8words mem_q [2**IDX_BITS];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/line_mem_responder.sv
// Memory-side responder for the cache's 128-bit line interface, one request in flight, fixed latency.
// Define LINE_MEM_ALIGN_CHECK_EN to flag (and suppress) accesses whose byte address is not line aligned.
module line_mem_responder
    import lc3b_types::*;
#(
    parameter int LATENCY  = LINE_MEM_LAT_DEF,
    parameter int IDX_BITS = LINE_IDX_BITS
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       mem_read,
    input  logic       mem_write,
    input  lc3b_word   mem_addr,
    input  lc3b_8words mem_wdata,
    output lc3b_8words mem_rdata,
    output logic       mem_resp,
    output logic       mem_err
);

    localparam logic [7:0] LAT_LAST = 8'(LATENCY - 1);

    lc3b_mem_state_t     state_q, state_d;
    logic [7:0]          cnt_q, cnt_d;
    logic                write_q, write_d;
    logic                err_q, err_d;
    logic [IDX_BITS-1:0] idx_q, idx_d;
    lc3b_8words          wdata_q, wdata_d;

    logic       acceptErr;
    logic       storeWe;
    lc3b_8words storeRdata;
    logic       unused_addr_bits;

    // Offset and aliasing upper address bits play no role in addressing.
    assign unused_addr_bits = ^mem_addr;

`ifdef LINE_MEM_ALIGN_CHECK_EN
    assign acceptErr = addr_misaligned(mem_addr);
`else
    assign acceptErr = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= MEM_IDLE;
            cnt_q   <= '0;
            write_q <= 1'b0;
            err_q   <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            write_q <= write_d;
            err_q   <= err_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
        end
    end

    // Write wins over read when both are requested; the request is latched so later bus changes are ignored.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        write_d = write_q;
        err_d   = err_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        unique case (state_q)
            MEM_IDLE: begin
                if (mem_read || mem_write) begin
                    write_d = mem_write;
                    err_d   = acceptErr;
                    idx_d   = mem_addr[4 +: IDX_BITS];
                    wdata_d = mem_wdata;
                    if (LATENCY == 1) begin
                        state_d = MEM_RESP;
                        cnt_d   = '0;
                    end else begin
                        state_d = MEM_BUSY;
                        cnt_d   = 8'd1;
                    end
                end
            end
            MEM_BUSY: begin
                if (cnt_q == LAT_LAST) begin
                    state_d = MEM_RESP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            MEM_RESP: begin
                state_d = MEM_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = MEM_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // The write lands on the RESP->IDLE edge, so a following read of the same line sees it.
    assign storeWe = (state_q == MEM_RESP) && write_q && !err_q;

    line_store #(
        .IDX_BITS(IDX_BITS)
    ) u_store (
        .clk_i  (clk),
        .we_i   (storeWe),
        .waddr_i(idx_q),
        .wdata_i(wdata_q),
        .raddr_i(idx_q),
        .rdata_o(storeRdata)
    );

    assign mem_resp  = (state_q == MEM_RESP);
    assign mem_err   = mem_resp && err_q;
    assign mem_rdata = (mem_resp && !write_q && !err_q) ? storeRdata : '0;

endmodule

// File: tb/tb_line_mem_responder.sv
// Self-checking bench for line_mem_responder: directed scenarios followed by random traffic
// checked against an associative-array model of memory. Honours LINE_MEM_ALIGN_CHECK_EN.
module tb_line_mem_responder;

    localparam int LAT = 4;
`ifdef LINE_MEM_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic         clk;
    logic         rst_n;
    logic         mem_read;
    logic         mem_write;
    logic [15:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata;
    logic         mem_resp;
    logic         mem_err;

    int errors = 0;
    int checks = 0;
    logic [127:0] model [int];

    line_mem_responder #(
        .LATENCY (LAT),
        .IDX_BITS(12)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .mem_read (mem_read),
        .mem_write(mem_write),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_resp (mem_resp),
        .mem_err  (mem_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // One handshake as the cache would perform it; dropAfter>0 lowers the request after that many edges.
    task automatic applyStimulus(input logic wr, input logic rd, input logic [15:0] addr,
                                 input logic [127:0] wd, input int dropAfter, input bit scramble);
        int  k;
        bit  got;
        int  idx;
        bit  expErr;
        idx    = int'(addr[15:4]);
        expErr = ALIGN && (addr[3:0] != 4'h0);
        @(negedge clk);
        mem_read  = rd;
        mem_write = wr;
        mem_addr  = addr;
        mem_wdata = wd;
        got = 1'b0;
        k   = 0;
        while (!got && k < LAT + 3) begin
            @(posedge clk);
            #1;
            k++;
            if (mem_resp) begin
                got = 1'b1;
            end else begin
                checkOutput("quietRdata", mem_rdata, '0);
                checkOutput("quietErr", 128'(mem_err), 128'(1'b0));
                if (k == dropAfter) begin
                    mem_read  = 1'b0;
                    mem_write = 1'b0;
                end
                if (scramble) begin
                    mem_addr  = 16'($urandom);
                    mem_wdata = rand128();
                end
            end
        end
        checkOutput("respSeen", 128'(got), 128'(1'b1));
        if (got) begin
            checkOutput("latency", 128'(k), 128'(LAT));
            checkOutput("errFlag", 128'(mem_err), 128'(expErr));
            if (!wr) begin
                if (expErr) begin
                    checkOutput("errRdata", mem_rdata, '0);
                end else if (model.exists(idx)) begin
                    checkOutput("readData", mem_rdata, model[idx]);
                end
            end
            if (wr && !expErr) begin
                model[idx] = wd;
            end
        end
        mem_read  = 1'b0;
        mem_write = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("singlePulse", 128'(mem_resp), 128'(1'b0));
    endtask

    initial begin
        logic [127:0] lineA;
        logic [127:0] lineB;
        logic [11:0]  ridx;
        logic [3:0]   roff;
        logic         rwr;
        logic         rrd;

        rst_n     = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        #1;
        checkOutput("rstResp", 128'(mem_resp), 128'(1'b0));
        checkOutput("rstRdata", mem_rdata, '0);
        checkOutput("rstErr", 128'(mem_err), 128'(1'b0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("postRstResp", 128'(mem_resp), 128'(1'b0));

        $display("[TB] read line 0x010");
        applyStimulus(1'b0, 1'b1, 16'h0100, '0, 0, 1'b0);

        $display("[TB] write then read 0x0230");
        applyStimulus(1'b1, 1'b0, 16'h0230, 128'hDEADBEEF_CAFEF00D_12345678_0BADBEEF, 0, 1'b0);
        applyStimulus(1'b0, 1'b1, 16'h0230, '0, 0, 1'b0);

        $display("[TB] read and write together at 0x0040");
        applyStimulus(1'b1, 1'b1, 16'h0040, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 0, 1'b0);
        applyStimulus(1'b0, 1'b1, 16'h0040, '0, 0, 1'b0);

        $display("[TB] request dropped and bus scrambled during busy");
        applyStimulus(1'b0, 1'b1, 16'h0230, '0, 1, 1'b1);
        applyStimulus(1'b1, 1'b0, 16'hF230, 128'h1111_2222_3333_4444_5555_6666_7777_8888, 2, 1'b1);
        applyStimulus(1'b0, 1'b1, 16'h0230, '0, 0, 1'b0);

        $display("[TB] reset during busy write to 0x0500");
        lineA = 128'hAAAA_0000_AAAA_0000_AAAA_0000_AAAA_0005;
        lineB = 128'hBBBB_1111_BBBB_1111_BBBB_1111_BBBB_1115;
        applyStimulus(1'b1, 1'b0, 16'h0500, lineA, 0, 1'b0);
        @(negedge clk);
        mem_write = 1'b1;
        mem_addr  = 16'h0500;
        mem_wdata = lineB;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("midRstResp", 128'(mem_resp), 128'(1'b0));
        checkOutput("midRstRdata", mem_rdata, '0);
        mem_write = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < LAT + 1; i++) begin
            @(posedge clk);
            #1;
            checkOutput("abortedResp", 128'(mem_resp), 128'(1'b0));
        end
        applyStimulus(1'b0, 1'b1, 16'h0500, '0, 0, 1'b0);

        $display("[TB] unaligned write to 0x0502");
        applyStimulus(1'b1, 1'b0, 16'h0502, 128'hC0C0_C0C0_C0C0_C0C0_C0C0_C0C0_C0C0_C0C0, 0, 1'b0);
        applyStimulus(1'b0, 1'b1, 16'h0500, '0, 0, 1'b0);
        applyStimulus(1'b0, 1'b1, 16'h0507, '0, 0, 1'b0);

        $display("[TB] random traffic");
        for (int n = 0; n < 60; n++) begin
            ridx = 12'h300 + 12'($urandom_range(0, 7));
            roff = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            rwr  = 1'($urandom);
            rrd  = rwr ? 1'($urandom) : 1'b1;
            applyStimulus(rwr, rrd, {ridx, roff}, rand128(),
                          ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, LAT - 1)) : 0,
                          1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
